// File: rtl/fetch_pkg.sv
// Shared types and constants for the SLC-3 PC/fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_HALTED   = 3'd0,
    ST_FETCH1   = 3'd1,
    ST_FETCH2   = 3'd2,
    ST_FETCH3   = 3'd3,
    ST_EXEC     = 3'd4,
    ST_PAUSED   = 3'd5,
    ST_CONT_REL = 3'd6
  } fetch_state_t;

  localparam logic [1:0] PCMUX_INC = 2'b00;
  localparam logic [1:0] PCMUX_ADR = 2'b01;
  localparam logic [1:0] PCMUX_BUS = 2'b10;

  localparam int MEM_WAIT_MIN = 1;
  localparam int MEM_WAIT_MAX = 15;
  localparam int CNT_W        = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing the memory read window; saturates at zero.
module mem_wait_counter
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             zero_next
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (dec && count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign zero      = (count_q == '0);
  // Lets the parent register LD_MDR one cycle ahead of the final wait cycle.
  assign zero_next = (count_d == '0);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute handshake FSM driving PC, MAR, MDR and IR load enables,
// with run/pause/single-step control from the board buttons.
module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic        Exec_Done,
  input  logic        Redirect,
  input  logic        Redirect_Src,
  input  logic        Pause_Req,
  output logic        Load_PC,
  output logic [1:0]  PCMUX,
  output logic        GatePC,
  output logic        LD_MAR,
  output logic        Mem_OE,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        Instr_Valid,
  output logic [2:0]  State_Out,
  output logic [15:0] Fetch_Count
);

  if (MEM_WAIT < MEM_WAIT_MIN || MEM_WAIT > MEM_WAIT_MAX) begin : g_bad_mem_wait
    $error("MEM_WAIT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);

  fetch_state_t state_q, state_d;
  logic [15:0]  fetch_count_q, fetch_count_d;
  logic         load_pc_q, load_pc_d;
  logic         gate_pc_q, gate_pc_d;
  logic         ld_mar_q, ld_mar_d;
  logic         mem_oe_q, mem_oe_d;
  logic         ld_mdr_q, ld_mdr_d;
  logic         ld_ir_q, ld_ir_d;
  logic         instr_valid_q, instr_valid_d;

  logic cnt_load, cnt_dec, cnt_zero, cnt_zero_next;
  logic redirect_now;

  assign cnt_load = (state_q == ST_FETCH1);
  assign cnt_dec  = (state_q == ST_FETCH2);

  mem_wait_counter u_wait (
    .clk       (Clk),
    .rst_n     (Reset),
    .load      (cnt_load),
    .load_val  (WAIT_LOAD),
    .dec       (cnt_dec),
    .zero      (cnt_zero),
    .zero_next (cnt_zero_next)
  );

  always_comb begin
    state_d       = state_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      ST_HALTED:   if (Run) state_d = ST_FETCH1;
      ST_FETCH1:   state_d = ST_FETCH2;
      ST_FETCH2:   if (cnt_zero) state_d = ST_FETCH3;
      ST_FETCH3: begin
        state_d       = ST_EXEC;
        fetch_count_d = fetch_count_q + 16'd1;
      end
      ST_EXEC:     if (Exec_Done) state_d = Pause_Req ? ST_PAUSED : ST_FETCH1;
      ST_PAUSED:   if (Continue) state_d = ST_CONT_REL;
      ST_CONT_REL: if (!Continue) state_d = ST_FETCH1;
      default:     state_d = ST_HALTED;
    endcase

    // Moore outputs are decoded from the next state so they register cleanly.
    load_pc_d     = (state_d == ST_FETCH1);
    gate_pc_d     = (state_d == ST_FETCH1);
    ld_mar_d      = (state_d == ST_FETCH1);
    mem_oe_d      = (state_d == ST_FETCH2);
    ld_mdr_d      = (state_d == ST_FETCH2) && cnt_zero_next;
    ld_ir_d       = (state_d == ST_FETCH3);
    instr_valid_d = (state_d == ST_EXEC);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_HALTED;
      fetch_count_q <= 16'h0000;
      load_pc_q     <= 1'b0;
      gate_pc_q     <= 1'b0;
      ld_mar_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
      ld_mdr_q      <= 1'b0;
      ld_ir_q       <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
      load_pc_q     <= load_pc_d;
      gate_pc_q     <= gate_pc_d;
      ld_mar_q      <= ld_mar_d;
      mem_oe_q      <= mem_oe_d;
      ld_mdr_q      <= ld_mdr_d;
      ld_ir_q       <= ld_ir_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // The redirect load happens in EXEC, where the registered PC+1 load is never set.
  assign redirect_now = (state_q == ST_EXEC) && Exec_Done && Redirect;
  assign Load_PC      = load_pc_q | redirect_now;
  assign PCMUX        = redirect_now ? (Redirect_Src ? PCMUX_BUS : PCMUX_ADR) : PCMUX_INC;

  assign GatePC      = gate_pc_q;
  assign LD_MAR      = ld_mar_q;
  assign Mem_OE      = mem_oe_q;
  assign LD_MDR      = ld_mdr_q;
  assign LD_IR       = ld_ir_q;
  assign Instr_Valid = instr_valid_q;
  assign State_Out   = state_q;
  assign Fetch_Count = fetch_count_q;

  a_no_pcmux11: assert property (@(posedge Clk) disable iff (!Reset) PCMUX != 2'b11);

endmodule
